hybrid_crypt_ctrl: RTL

Parametrised sequencer for the HEA hybrid-encryption datapath. It drives an external RSA core and AES-128 core over start/done handshakes. It streams header and payload words to and from the CPU over a BUS_W-wide valid/ready interface. It supports encrypt and decrypt modes and multi-block messages, and includes a watchdog on each core operation. It sits between the CPU bus adapter and the `rsa_core` / `aes128_core` instances.

---
 rtl/hea_pkg.sv | 25 ++
 rtl/hea_word_shifter.sv | 72 +++++++
 rtl/hybrid_crypt_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hea_pkg.sv
// hea_pkg
//   Shared definitions for the HEA hybrid-encryption sequencer:
//   - hea_state_t   : sequencer state encoding
//   - HEA_MODE_*    : encrypt / decrypt mode values
//   - HEA_KEY_W/BUS_W : default key and CPU stream widths
package hea_pkg;

  localparam int HEA_KEY_W = 128;
  localparam int HEA_BUS_W = 32;

  localparam logic HEA_MODE_ENC = 1'b0;
  localparam logic HEA_MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RSA_RUN,
    HDR_OUT,
    HDR_IN,
    BLK_IN,
    AES_RUN,
    BLK_OUT,
    FINISH
  } hea_state_t;

endpackage

// File: rtl/hea_word_shifter.sv
// hea_word_shifter
//   KEY_W-wide register that is filled or drained one BUS_W word at a time,
//   most-significant word first, or loaded in parallel. A word counter flags
//   the last word of a KEY_W group and wraps on it.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clr            : clear data and word counter
//   load/load_data : parallel load (resets the word counter)
//   shift_in/in_word : shift a word in at the LSW end
//   shift_out      : drop the MSW, zero-fill the LSW end
//   out_word       : current MSW
//   data_in_next   : register value after a shift_in of in_word
//   last           : counter is on the final word of the group
module hea_word_shifter
  import hea_pkg::*;
#(
  parameter int KEY_W = HEA_KEY_W,
  parameter int BUS_W = HEA_BUS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [KEY_W-1:0] load_data,
  input  logic             shift_in,
  input  logic [BUS_W-1:0] in_word,
  input  logic             shift_out,
  output logic [BUS_W-1:0] out_word,
  output logic [KEY_W-1:0] data_in_next,
  output logic             last
);

  localparam int WORDS = KEY_W / BUS_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [KEY_W-1:0] data_reg;
  logic [KEY_W-1:0] data_shift;
  logic [CNT_W-1:0] cnt_reg;

  generate
    if (WORDS > 1) begin : g_multi
      assign data_in_next = {data_reg[KEY_W-BUS_W-1:0], in_word};
      assign data_shift   = {data_reg[KEY_W-BUS_W-1:0], {BUS_W{1'b0}}};
    end else begin : g_single
      assign data_in_next = in_word;
      assign data_shift   = '0;
    end
  endgenerate

  assign out_word = data_reg[KEY_W-1 -: BUS_W];
  assign last     = (cnt_reg == CNT_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (clr) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      data_reg <= load_data;
      cnt_reg  <= '0;
    end else if (shift_in) begin
      data_reg <= data_in_next;
      cnt_reg  <= last ? '0 : cnt_reg + CNT_W'(1);
    end else if (shift_out) begin
      data_reg <= data_shift;
      cnt_reg  <= last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hybrid_crypt_ctrl.sv
// hybrid_crypt_ctrl
//   Sequencer for the HEA hybrid-encryption datapath. Drives an external RSA
//   core (key wrap/unwrap) and AES-128 core (block transform) over start/done
//   handshakes and streams header/payload words to/from the CPU, MSW first.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   start_i, mode_i, num_blocks_i, sym_key_i : message request (latched in IDLE)
//   in_valid_i/in_data_i/in_ready_o    : CPU -> block word stream
//   out_valid_o/out_data_o/out_ready_i : block -> CPU word stream
//   rsa_*                         : RSA core handshake and operands
//   aes_*                         : AES core handshake and operands
//   busy_o, done_o, err_o         : status (done/err are one-cycle pulses)
module hybrid_crypt_ctrl
  import hea_pkg::*;
#(
  parameter int BUS_W       = HEA_BUS_W,
  parameter int KEY_W       = HEA_KEY_W,
  parameter int MAX_BLOCKS  = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            mode_i,
  input  logic [$clog2(MAX_BLOCKS+1)-1:0] num_blocks_i,
  input  logic [KEY_W-1:0]                sym_key_i,
  input  logic                            in_valid_i,
  input  logic [BUS_W-1:0]                in_data_i,
  output logic                            in_ready_o,
  output logic                            out_valid_o,
  output logic [BUS_W-1:0]                out_data_o,
  input  logic                            out_ready_i,
  output logic                            rsa_start_o,
  output logic                            rsa_decrypt_o,
  output logic [KEY_W-1:0]                rsa_msg_o,
  input  logic [KEY_W-1:0]                rsa_result_i,
  input  logic                            rsa_done_i,
  output logic                            aes_start_o,
  output logic                            aes_decrypt_o,
  output logic [KEY_W-1:0]                aes_key_o,
  output logic [KEY_W-1:0]                aes_block_o,
  input  logic [KEY_W-1:0]                aes_result_i,
  input  logic                            aes_done_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o
);

  localparam int NB_W = $clog2(MAX_BLOCKS + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [NB_W-1:0] MAX_NB = NB_W'(MAX_BLOCKS);

  hea_state_t       state_reg;
  logic             mode_reg;
  logic [NB_W-1:0]  blk_rem_reg;
  logic [WD_W-1:0]  wdog_reg;
  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] rsa_msg_reg;
  logic [KEY_W-1:0] aes_block_reg;
  logic             rsa_dec_reg;
  logic             rsa_start_reg;
  logic             aes_start_reg;
  logic             done_reg;
  logic             err_reg;

  logic             in_fire, out_fire, rsa_ack, aes_ack, wd_expired, start_go;
  logic             sh_load, sh_last;
  logic [KEY_W-1:0] sh_load_data, sh_in_next;
  logic [NB_W-1:0]  nb_clamped;

  assign in_ready_o  = (state_reg == HDR_IN) || (state_reg == BLK_IN);
  assign out_valid_o = (state_reg == HDR_OUT) || (state_reg == BLK_OUT);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;
  assign start_go    = (state_reg == IDLE) && start_i;

  // A done coinciding with our own start pulse belongs to no operation of ours.
  assign rsa_ack    = (state_reg == RSA_RUN) && rsa_done_i && !rsa_start_reg;
  assign aes_ack    = (state_reg == AES_RUN) && aes_done_i && !aes_start_reg;
  assign wd_expired = (wdog_reg == WD_W'(TIMEOUT_CYC - 1));
  assign nb_clamped = (num_blocks_i > MAX_NB) ? MAX_NB : num_blocks_i;

  // Shifter is loaded with the RSA header (encrypt only) or the AES result.
  assign sh_load      = (rsa_ack && (mode_reg == HEA_MODE_ENC)) || aes_ack;
  assign sh_load_data = aes_ack ? aes_result_i : rsa_result_i;

  hea_word_shifter #(
    .KEY_W (KEY_W),
    .BUS_W (BUS_W)
  ) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (start_go),
    .load         (sh_load),
    .load_data    (sh_load_data),
    .shift_in     (in_fire),
    .in_word      (in_data_i),
    .shift_out    (out_fire),
    .out_word     (out_data_o),
    .data_in_next (sh_in_next),
    .last         (sh_last)
  );

  assign busy_o        = (state_reg != IDLE);
  assign done_o        = done_reg;
  assign err_o         = err_reg;
  assign rsa_start_o   = rsa_start_reg;
  assign rsa_decrypt_o = rsa_dec_reg;
  assign rsa_msg_o     = rsa_msg_reg;
  assign aes_start_o   = aes_start_reg;
  assign aes_decrypt_o = (mode_reg == HEA_MODE_DEC);
  assign aes_key_o     = key_reg;
  assign aes_block_o   = aes_block_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mode_reg      <= HEA_MODE_ENC;
      blk_rem_reg   <= '0;
      wdog_reg      <= '0;
      key_reg       <= '0;
      rsa_msg_reg   <= '0;
      aes_block_reg <= '0;
      rsa_dec_reg   <= 1'b0;
      rsa_start_reg <= 1'b0;
      aes_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      rsa_start_reg <= 1'b0;
      aes_start_reg <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            mode_reg    <= mode_i;
            blk_rem_reg <= nb_clamped;
            wdog_reg    <= '0;
            if (mode_i == HEA_MODE_ENC) begin
              key_reg       <= sym_key_i;
              rsa_msg_reg   <= sym_key_i;
              rsa_dec_reg   <= 1'b0;
              rsa_start_reg <= 1'b1;
              state_reg     <= RSA_RUN;
            end else begin
              key_reg   <= '0;
              state_reg <= HDR_IN;
            end
          end
        end
        RSA_RUN: begin
          wdog_reg <= wdog_reg + WD_W'(1);
          if (rsa_ack) begin
            if (mode_reg == HEA_MODE_ENC) begin
              state_reg <= HDR_OUT;
            end else begin
              key_reg <= rsa_result_i;
              if (blk_rem_reg == '0) begin
                done_reg  <= 1'b1;
                state_reg <= FINISH;
              end else begin
                state_reg <= BLK_IN;
              end
            end
          end else if (wd_expired) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        HDR_OUT: begin
          if (out_fire && sh_last) begin
            if (blk_rem_reg == '0) begin
              done_reg  <= 1'b1;
              state_reg <= FINISH;
            end else begin
              state_reg <= BLK_IN;
            end
          end
        end
        HDR_IN: begin
          if (in_fire && sh_last) begin
            rsa_msg_reg   <= sh_in_next;
            rsa_dec_reg   <= 1'b1;
            rsa_start_reg <= 1'b1;
            wdog_reg      <= '0;
            state_reg     <= RSA_RUN;
          end
        end
        BLK_IN: begin
          if (in_fire && sh_last) begin
            aes_block_reg <= sh_in_next;
            aes_start_reg <= 1'b1;
            wdog_reg      <= '0;
            state_reg     <= AES_RUN;
          end
        end
        AES_RUN: begin
          wdog_reg <= wdog_reg + WD_W'(1);
          if (aes_ack) begin
            state_reg <= BLK_OUT;
          end else if (wd_expired) begin
            err_reg   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        BLK_OUT: begin
          if (out_fire && sh_last) begin
            blk_rem_reg <= blk_rem_reg - NB_W'(1);
            if (blk_rem_reg == NB_W'(1)) begin
              done_reg  <= 1'b1;
              state_reg <= FINISH;
            end else begin
              state_reg <= BLK_IN;
            end
          end
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
